wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter that sits directly downstream of the per-pipe writeback registers (ALU, MEM, MUL/M5) and owns the single ROB write port. Each cycle it grants at most one valid producer, registers that producer's result onto the ROB write port, and asserts a stall back to every valid producer it did not grant, so the losing pipe register holds its contents. The fourth cycle of a load/multiply chain therefore ends here, one registered cycle before the ROB entry is marked complete.

## Interface
- WORD_SIZE, 32, width of pc and result
- INSTR_TYPE_SZ, 2, width of instruction type field
- ROB_ENTRY_WIDTH, 3, width of ROB index
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous pipeline flush (branch mispredict / exception)
- src_valid  input  3  per-source valid; index 0=ALU, 1=MEM, 2=MUL
- src_type  input  3*INSTR_TYPE_SZ  per-source instruction type, packed by index
- src_pc  input  3*WORD_SIZE  per-source pc
- src_result  input  3*WORD_SIZE  per-source result
- src_rob_id  input  3*ROB_ENTRY_WIDTH  per-source ROB index
- src_stall  output  3  per-source stall; source must hold its register while high
- rob_wr_en  output  1  ROB write strobe
- rob_wr_type  output  INSTR_TYPE_SZ  written instruction type
- rob_wr_pc  output  WORD_SIZE  written pc
- rob_wr_value  output  WORD_SIZE  written result
- rob_wr_id  output  ROB_ENTRY_WIDTH  target ROB entry

## Operation
- Grant logic combinational on src_valid and priority state; exactly one grant if any src_valid=1, none otherwise.
- src_stall[i] = src_valid[i] & ~grant[i] & ~flush; never asserted for an invalid source or the granted source.
- On clock edge: rob_wr_en <= |grant & ~flush; fields of granted source copied to rob_wr_*; if no grant, data fields hold previous value, only rob_wr_en drops.
- Priority state: 2-bit last_grant register (values 0..2). Updated to granted index on every edge with a grant and no flush; unchanged otherwise.
- flush: highest priority after reset; next edge rob_wr_en=0, no grant, src_stall all 0 during flush cycle, last_grant unchanged.
- Reset (asynchronous, reset=0): rob_wr_en=0, rob_wr_type=0, rob_wr_pc=0, rob_wr_value=0, rob_wr_id=0, last_grant=2; src_stall forced 0 while reset low. Reset mid-stall drops the pending grant; sources are reset by their own registers.
- No ready/back-pressure from ROB: write port accepts every cycle.

## Timing
- Latency: source valid in cycle N, granted -> rob_wr_en high in cycle N+1.
- Throughput: one write per cycle; k simultaneous valids drain in k cycles.
- Stall is same-cycle combinational from src_valid; producer registers sample it on the same edge the arbiter registers the winner.
- A stalled source keeps valid high; it is granted no later than 2 cycles later under round-robin (bounded starvation).
- Reset release synchronous to clk is the integrator's responsibility; first grant possible on first edge with reset=1.

## Configuration
- WB_ROUND_ROBIN_EN defined: round-robin; search order starts at (last_grant+1) mod 3 and wraps; index 2 wraps to 0.
- WB_ROUND_ROBIN_EN undefined: fixed priority MEM(1) > MUL(2) > ALU(0); last_grant register still present and updated but ignored; starvation of ALU is permitted.

## Test plan
- Reset: hold reset=0 with src_valid=3'b111 -> all outputs 0, src_stall=3'b000; release -> first edge writes ALU entry (round-robin) or MEM entry (fixed).
- Single source: src_valid=3'b100, rob_id=5, result=0xDEADBEEF, pc=0x40 -> next cycle rob_wr_en=1, rob_wr_id=5, rob_wr_value=0xDEADBEEF, rob_wr_pc=0x40; src_stall=0.
- Full contention, round-robin: src_valid=3'b111 held for 3 cycles, sources dropping valid once granted -> writes in order ALU, MEM, MUL on cycles 1,2,3; stalls 3'b110, 3'b100, 3'b000.
- Fixed priority (macro off): src_valid=3'b111 -> write order MEM, MUL, ALU; ALU stalled 2 cycles.
- Flush during contention: src_valid=3'b011 with flush=1 -> src_stall=0, next cycle rob_wr_en=0, last_grant unchanged; following cycle with flush=0 resumes expected order.
- Async reset mid-operation: assert reset=0 between edges while rob_wr_en=1 -> rob_wr_en and all fields 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of ALU/MEM/MUL per cycle for the single ROB write port.
// Latency: 1 cycle, from valid+grant to rob_wr_en. Arbitration policy selected by WB_ROUND_ROBIN_EN.
// Backpressure: losing valid sources see a combinational src_stall and hold; the ROB never stalls us.
module wb_arbiter #(
    parameter int WORD_SIZE       = 32,
    parameter int INSTR_TYPE_SZ   = 2,
    parameter int ROB_ENTRY_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [2:0]                   src_valid,
    input  logic [3*INSTR_TYPE_SZ-1:0]   src_type,
    input  logic [3*WORD_SIZE-1:0]       src_pc,
    input  logic [3*WORD_SIZE-1:0]       src_result,
    input  logic [3*ROB_ENTRY_WIDTH-1:0] src_rob_id,
    output logic [2:0]                   src_stall,
    output logic                         rob_wr_en,
    output logic [INSTR_TYPE_SZ-1:0]     rob_wr_type,
    output logic [WORD_SIZE-1:0]         rob_wr_pc,
    output logic [WORD_SIZE-1:0]         rob_wr_value,
    output logic [ROB_ENTRY_WIDTH-1:0]   rob_wr_id
);

    // Index of the most recently granted source; reset value 2 makes ALU first in round-robin.
    logic [1:0] last_grant;
    logic [2:0] grant;
    logic [1:0] gnt_idx;
    logic       any_grant;

    logic [INSTR_TYPE_SZ-1:0]   type_arr [3];
    logic [WORD_SIZE-1:0]       pc_arr   [3];
    logic [WORD_SIZE-1:0]       res_arr  [3];
    logic [ROB_ENTRY_WIDTH-1:0] id_arr   [3];

    // Unpack the per-source buses so the granted source can be selected by index.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            type_arr[i] = src_type[i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
            pc_arr[i]   = src_pc[i*WORD_SIZE +: WORD_SIZE];
            res_arr[i]  = src_result[i*WORD_SIZE +: WORD_SIZE];
            id_arr[i]   = src_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
        end
    end

    // One-hot grant; a flush suppresses arbitration entirely.
    always_comb begin
        grant = 3'b000;
        if (!flush) begin
`ifdef WB_ROUND_ROBIN_EN
            // Search starts just after the last winner and wraps 2 -> 0.
            case (last_grant)
                2'd0: begin
                    if      (src_valid[1]) grant = 3'b010;
                    else if (src_valid[2]) grant = 3'b100;
                    else if (src_valid[0]) grant = 3'b001;
                end
                2'd1: begin
                    if      (src_valid[2]) grant = 3'b100;
                    else if (src_valid[0]) grant = 3'b001;
                    else if (src_valid[1]) grant = 3'b010;
                end
                default: begin
                    if      (src_valid[0]) grant = 3'b001;
                    else if (src_valid[1]) grant = 3'b010;
                    else if (src_valid[2]) grant = 3'b100;
                end
            endcase
`else
            // Fixed order MEM > MUL > ALU; ALU may starve under sustained load.
            if      (src_valid[1]) grant = 3'b010;
            else if (src_valid[2]) grant = 3'b100;
            else if (src_valid[0]) grant = 3'b001;
`endif
        end
    end

    // Encode the winner and derive stalls; stalls are held low during reset and flush.
    always_comb begin
        gnt_idx = 2'd0;
        if (grant[1])      gnt_idx = 2'd1;
        else if (grant[2]) gnt_idx = 2'd2;
        any_grant = |grant;
        src_stall = reset ? (src_valid & ~grant & {3{~flush}}) : 3'b000;
    end

    // Register the winner onto the ROB port; data fields hold when nothing is granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rob_wr_en    <= 1'b0;
            rob_wr_type  <= '0;
            rob_wr_pc    <= '0;
            rob_wr_value <= '0;
            rob_wr_id    <= '0;
            last_grant   <= 2'd2;
        end else begin
            rob_wr_en <= any_grant;
            if (any_grant) begin
                rob_wr_type  <= type_arr[gnt_idx];
                rob_wr_pc    <= pc_arr[gnt_idx];
                rob_wr_value <= res_arr[gnt_idx];
                rob_wr_id    <= id_arr[gnt_idx];
                last_grant   <= gnt_idx;
            end else begin
                last_grant   <= last_grant;
            end
        end
    end

endmodule
